// File: rtl/mdu_pkg.sv
// Shared constants and state encodings for the M-extension divide unit.
// The DIVIDER_SIGNED_EN build macro is consumed by divider.sv.
package mdu_pkg;

    localparam int XLEN        = 32;
    localparam int ITERS       = 32;
    localparam int DIV_LATENCY = 34;
    localparam int CNT_W       = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;
    localparam logic [XLEN-1:0]  DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: used for operand magnitudes and
// for the final quotient/remainder sign correction.
module div_sign_fix
    import mdu_pkg::*;
(
    input  logic            neg_i,
    input  logic [XLEN-1:0] val_i,
    output logic [XLEN-1:0] res_o
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        res_o = val_i;
        if (neg_i) begin
            res_o = {XLEN{1'b0}} - val_i;
        end else begin
            res_o = val_i;
        end
    end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring 32-bit divider, 34-cycle latency and throughput.
// Define DIVIDER_SIGNED_EN to honour signed_i; otherwise all operations are unsigned.
module divider
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            signed_i,
    input  logic            vld_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o,
    output logic            rdy_o,
    output logic            busy_o
);

    div_state_e        state_r;
    div_state_e        state_nxt_s;
    logic              fire_s;

    logic [XLEN:0]     rem_r;
    logic [XLEN-1:0]   q_r;
    logic [XLEN-1:0]   dvs_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   rem_out_r;
    logic              rdy_r;

    logic [XLEN:0]     shift_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN:0]     rem_step_s;
    logic [XLEN-1:0]   q_step_s;

    logic [XLEN-1:0]   dvd_abs_s;
    logic [XLEN-1:0]   dvs_abs_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;

`ifdef DIVIDER_SIGNED_EN
    logic              sa_s;
    logic              sb_s;
    logic              sgn_quo_r;
    logic              sgn_rem_r;
    logic              div0_r;

    assign sa_s = dividend_i[XLEN-1] & signed_i;
    assign sb_s = divisor_i[XLEN-1]  & signed_i;

    div_sign_fix u_abs_dvd (.neg_i(sa_s), .val_i(dividend_i), .res_o(dvd_abs_s));
    div_sign_fix u_abs_dvs (.neg_i(sb_s), .val_i(divisor_i),  .res_o(dvs_abs_s));

    // Quotient negation is suppressed on divide-by-zero so it stays all ones.
    div_sign_fix u_fix_quo (.neg_i(sgn_quo_r & ~div0_r), .val_i(q_r),
                            .res_o(quo_fix_s));
    div_sign_fix u_fix_rem (.neg_i(sgn_rem_r), .val_i(rem_r[XLEN-1:0]),
                            .res_o(rem_fix_s));

    // Operand sign bookkeeping captured at fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_quo_r <= 1'b0;
            sgn_rem_r <= 1'b0;
            div0_r    <= 1'b0;
        end else if (fire_s) begin
            sgn_quo_r <= sa_s ^ sb_s;
            sgn_rem_r <= sa_s;
            div0_r    <= (divisor_i == {XLEN{1'b0}});
        end else begin
            sgn_quo_r <= sgn_quo_r;
            sgn_rem_r <= sgn_rem_r;
            div0_r    <= div0_r;
        end
    end
`else
    logic              sign_unused_s;

    assign sign_unused_s = signed_i;
    assign dvd_abs_s     = dividend_i;
    assign dvs_abs_s     = divisor_i;
    assign quo_fix_s     = q_r;
    assign rem_fix_s     = rem_r[XLEN-1:0];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a request is only taken while idle.
    always_comb begin
        state_nxt_s = state_r;
        fire_s      = 1'b0;
        case (state_r)
            DIV_IDLE: begin
                if (vld_i) begin
                    fire_s      = 1'b1;
                    state_nxt_s = DIV_CALC;
                end else begin
                    state_nxt_s = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DIV_FIX;
                end else begin
                    state_nxt_s = DIV_CALC;
                end
            end
            DIV_FIX:  state_nxt_s = DIV_IDLE;
            default:  state_nxt_s = DIV_IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shift_s = {rem_r[XLEN-1:0], q_r[XLEN-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
        if (shift_s >= {1'b0, dvs_r}) begin
            rem_step_s = diff_s;
            q_step_s   = {q_r[XLEN-2:0], 1'b1};
        end else begin
            rem_step_s = shift_s;
            q_step_s   = {q_r[XLEN-2:0], 1'b0};
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r     <= {(XLEN+1){1'b0}};
            q_r       <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            rem_out_r <= {XLEN{1'b0}};
            rdy_r     <= 1'b0;
        end else begin
            rdy_r <= 1'b0;
            case (state_r)
                DIV_IDLE: begin
                    if (fire_s) begin
                        rem_r <= {(XLEN+1){1'b0}};
                        q_r   <= dvd_abs_s;
                        dvs_r <= dvs_abs_s;
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DIV_CALC: begin
                    rem_r <= rem_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                DIV_FIX: begin
                    quo_r     <= quo_fix_s;
                    rem_out_r <= rem_fix_s;
                    rdy_r     <= 1'b1;
                end
                default: begin
                    rdy_r <= 1'b0;
                end
            endcase
        end
    end

    assign quo_o  = quo_r;
    assign rem_o  = rem_out_r;
    assign rdy_o  = rdy_r;
    assign busy_o = (state_r != DIV_IDLE);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table plus back-to-back and reset-abort sequences.
module tb_divider;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        sgn;
    logic        vld;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        rdy;
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    vec_t vecs [10];

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .dividend_i(dividend),
        .divisor_i (divisor),
        .signed_i  (sgn),
        .vld_i     (vld),
        .quo_o     (quo),
        .rem_o     (rem),
        .rdy_o     (rdy),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Fire one operation from idle and check latency, results and pulse width.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input string nm);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sgn      = s;
        vld      = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            vld = 1'b0;
            if (n == 1) chk({nm, " busy"}, {31'd0, busy}, 32'd1);
            if (rdy) lat = n;
        end
        chk({nm, " latency"}, lat, DIV_LATENCY);
        chk({nm, " quo"}, quo, eq);
        chk({nm, " rem"}, rem, er);
        @(negedge clk);
        chk({nm, " rdy_pulse"}, {31'd0, rdy}, 32'd0);
    endtask

    initial begin
        int pulses;
        checks   = 0;
        failures = 0;

`ifdef DIVIDER_SIGNED_EN
        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,       32'd2};
        vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{32'h00001234,   32'd0,          1'b0, DIV0_QUO,     32'h00001234};
        vecs[3] = '{32'hFFFFFFFB,   32'd0,          1'b1, DIV0_QUO,     32'hFFFFFFFB};
        vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0};
        vecs[5] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF, 32'd0};
        vecs[6] = '{32'd9,          32'd4,          1'b0, 32'd2,        32'd1};
        vecs[7] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1};
        vecs[8] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,       32'hFFFFFFFE};
        vecs[9] = '{32'd0,          32'd5,          1'b1, 32'd0,        32'd0};
`else
        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,       32'd2};
        vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'h7FFFFFFC, 32'd1};
        vecs[2] = '{32'h00001234,   32'd0,          1'b0, DIV0_QUO,     32'h00001234};
        vecs[3] = '{32'hFFFFFFFB,   32'd0,          1'b1, DIV0_QUO,     32'hFFFFFFFB};
        vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'd0,        32'h80000000};
        vecs[5] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF, 32'd0};
        vecs[6] = '{32'd9,          32'd4,          1'b0, 32'd2,        32'd1};
        vecs[7] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'd0,        32'd7};
        vecs[8] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd0,        32'hFFFFFF9C};
        vecs[9] = '{32'd0,          32'd5,          1'b1, 32'd0,        32'd0};
`endif

        rst      = 1'b1;
        vld      = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        sgn      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset quo",  quo, 32'd0);
        chk("reset rem",  rem, 32'd0);
        chk("reset rdy",  {31'd0, rdy}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].eq, vecs[i].er,
                   $sformatf("vec%0d", i));
        end

        // Back-to-back: vld held high, operands swapped mid-operation.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        sgn      = 1'b0;
        vld      = 1'b1;
        @(posedge clk);
        pulses = 0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (n == 1) begin
                dividend = 32'd20;
                divisor  = 32'd3;
            end
            if (n == 35) vld = 1'b0;
            if (rdy) begin
                pulses++;
                if (pulses == 1) begin
                    chk("b2b first_cycle", n, 32'd34);
                    chk("b2b first_quo", quo, 32'd14);
                    chk("b2b first_rem", rem, 32'd2);
                end else begin
                    chk("b2b second_cycle", n, 32'd68);
                    chk("b2b second_quo", quo, 32'd6);
                    chk("b2b second_rem", rem, 32'd2);
                end
            end
        end
        chk("b2b pulses", pulses, 32'd2);

        // Reset at cycle 10 of an operation aborts it.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        vld      = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            vld = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort quo",  quo, 32'd0);
        chk("abort rem",  rem, 32'd0);
        chk("abort rdy",  {31'd0, rdy}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        chk("abort no_rdy", pulses, 32'd0);
        run_op(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
